// File: rtl/hazard_scoreboard.sv
// Register scoreboard beside decode: tracks pending writes of variable-latency
// producers and reports RAW/WAW stalls plus bypass age for each source operand.
module hazard_scoreboard #(
    parameter int NREGS = 32,
    parameter int ADDRW = $clog2(NREGS),
    parameter int LATW  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ADDRW-1:0] dec_rs1,
    input  logic [ADDRW-1:0] dec_rs2,
    input  logic             dec_rs1_en,
    input  logic             dec_rs2_en,
    input  logic [ADDRW-1:0] dec_rd,
    input  logic             dec_rd_en,
    input  logic [LATW-1:0]  dec_wb_lat,
    output logic             stall,
    output logic             rs1_byp,
    output logic             rs2_byp,
    output logic [LATW-1:0]  rs1_age,
    output logic [LATW-1:0]  rs2_age,
    input  logic             iss_valid,
    input  logic [ADDRW-1:0] iss_rd,
    input  logic [LATW-1:0]  iss_rdy_lat,
    input  logic [LATW-1:0]  iss_wb_lat,
    input  logic             clear,
    output logic [NREGS-1:0] busy_mask,
    output logic [ADDRW:0]   pending_count
);

    logic            busy [NREGS];
    logic [LATW-1:0] rdy  [NREGS];
    logic [LATW-1:0] wb   [NREGS];
    logic [LATW-1:0] age  [NREGS];

    logic [LATW-1:0] iss_wb_eff;
    logic [LATW-1:0] iss_rdy_eff;

    // A zero write-back latency would never retire, so it is promoted to one.
    assign iss_wb_eff  = (iss_wb_lat == '0) ? LATW'(1) : iss_wb_lat;
    assign iss_rdy_eff = (iss_rdy_lat < iss_wb_eff) ? iss_rdy_lat : iss_wb_eff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                busy[r] <= 1'b0;
                rdy[r]  <= '0;
                wb[r]   <= '0;
                age[r]  <= '0;
            end
        end else if (clear) begin
            for (int r = 0; r < NREGS; r++) begin
                busy[r] <= 1'b0;
                rdy[r]  <= '0;
                wb[r]   <= '0;
                age[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == 0) begin
                    busy[r] <= 1'b0;
                    rdy[r]  <= '0;
                    wb[r]   <= '0;
                    age[r]  <= '0;
                end else if (iss_valid && iss_rd == ADDRW'(r)) begin
                    busy[r] <= 1'b1;
                    rdy[r]  <= iss_rdy_eff;
                    wb[r]   <= iss_wb_eff;
                    age[r]  <= '0;
                end else if (busy[r]) begin
                    // wb is never 0 while busy, so reaching 1 means this edge retires it.
                    if (wb[r] == LATW'(1)) begin
                        busy[r] <= 1'b0;
                        rdy[r]  <= '0;
                        wb[r]   <= '0;
                        age[r]  <= '0;
                    end else begin
                        wb[r]  <= wb[r] - LATW'(1);
                        rdy[r] <= (rdy[r] == '0) ? '0 : rdy[r] - LATW'(1);
                        age[r] <= (age[r] == '1) ? age[r] : age[r] + LATW'(1);
                    end
                end
            end
        end
    end

    logic [ADDRW:0] cnt;

    always_comb begin
        busy_mask = '0;
        cnt       = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_mask[r] = busy[r];
            cnt          = cnt + {{ADDRW{1'b0}}, busy[r]};
        end
        pending_count = cnt;
    end

    logic live1, live2, haz1, haz2, waw;

    always_comb begin
        live1   = dec_rs1_en && (dec_rs1 != '0) && busy[dec_rs1];
        live2   = dec_rs2_en && (dec_rs2 != '0) && busy[dec_rs2];
        haz1    = live1 && (rdy[dec_rs1] != '0);
        haz2    = live2 && (rdy[dec_rs2] != '0);
        rs1_byp = live1 && (rdy[dec_rs1] == '0);
        rs2_byp = live2 && (rdy[dec_rs2] == '0);
        rs1_age = rs1_byp ? age[dec_rs1] : '0;
        rs2_age = rs2_byp ? age[dec_rs2] : '0;
        waw     = dec_rd_en && (dec_rd != '0) && busy[dec_rd] && (wb[dec_rd] > dec_wb_lat);
        stall   = haz1 || haz2 || waw;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by random
// traffic, all checked against a cycle-timestamp model of each register's producer.
module tb_hazard_scoreboard;

    localparam int NREGS = 32;
    localparam int ADDRW = 5;
    localparam int LATW  = 3;
    localparam int AMAX  = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [ADDRW-1:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic             dec_rs1_en = 1'b0, dec_rs2_en = 1'b0, dec_rd_en = 1'b0;
    logic [LATW-1:0]  dec_wb_lat = '0;
    logic             stall, rs1_byp, rs2_byp;
    logic [LATW-1:0]  rs1_age, rs2_age;
    logic             iss_valid = 1'b0;
    logic [ADDRW-1:0] iss_rd = '0;
    logic [LATW-1:0]  iss_rdy_lat = '0, iss_wb_lat = '0;
    logic             clear = 1'b0;
    logic [NREGS-1:0] busy_mask;
    logic [ADDRW:0]   pending_count;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.NREGS(NREGS), .ADDRW(ADDRW), .LATW(LATW)) dut (
        .clock(clock), .reset(reset),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_wb_lat(dec_wb_lat),
        .stall(stall), .rs1_byp(rs1_byp), .rs2_byp(rs2_byp),
        .rs1_age(rs1_age), .rs2_age(rs2_age),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_rdy_lat(iss_rdy_lat), .iss_wb_lat(iss_wb_lat),
        .clear(clear), .busy_mask(busy_mask), .pending_count(pending_count)
    );

    always #5 clock = ~clock;

    // Model: each register remembers the edge number its producer issued on,
    // when its result becomes bypassable and when it reaches the register file.
    int cyc = 0;
    int issC [NREGS];
    int rdyC [NREGS];
    int retC [NREGS];

    function automatic bit mBusy(int r);
        return (r != 0) && (retC[r] > cyc);
    endfunction

    function automatic bit mHaz(bit en, int r);
        return en && mBusy(r) && (rdyC[r] > cyc);
    endfunction

    function automatic bit mByp(bit en, int r);
        return en && mBusy(r) && (rdyC[r] <= cyc);
    endfunction

    function automatic int mAge(bit en, int r);
        int a;
        if (!mByp(en, r)) return 0;
        a = cyc - issC[r];
        return (a > AMAX) ? AMAX : a;
    endfunction

    task automatic modelClear();
        for (int r = 0; r < NREGS; r++) begin
            issC[r] = 0;
            rdyC[r] = 0;
            retC[r] = 0;
        end
    endtask

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(string tag);
        logic [31:0] expMask;
        int          expCnt;
        bit          expStall;
        int          wbLeft;
        expMask = '0;
        expCnt  = 0;
        for (int r = 0; r < NREGS; r++) begin
            if (mBusy(r)) begin
                expMask[r] = 1'b1;
                expCnt++;
            end
        end
        wbLeft   = retC[dec_rd] - cyc;
        expStall = mHaz(dec_rs1_en, int'(dec_rs1)) || mHaz(dec_rs2_en, int'(dec_rs2)) ||
                   (dec_rd_en && mBusy(int'(dec_rd)) && (wbLeft > int'(dec_wb_lat)));
        checkVal({tag, ".mask"},  32'(busy_mask), expMask);
        checkVal({tag, ".count"}, 32'(pending_count), 32'(expCnt));
        checkVal({tag, ".stall"}, 32'(stall), 32'(expStall));
        checkVal({tag, ".byp1"},  32'(rs1_byp), 32'(mByp(dec_rs1_en, int'(dec_rs1))));
        checkVal({tag, ".byp2"},  32'(rs2_byp), 32'(mByp(dec_rs2_en, int'(dec_rs2))));
        checkVal({tag, ".age1"},  32'(rs1_age), 32'(mAge(dec_rs1_en, int'(dec_rs1))));
        checkVal({tag, ".age2"},  32'(rs2_age), 32'(mAge(dec_rs2_en, int'(dec_rs2))));
    endtask

    // One clock edge: the model consumes the issue/clear inputs held across it.
    task automatic applyStimulus();
        int w, rd;
        @(posedge clock);
        cyc++;
        if (reset || clear) begin
            modelClear();
        end else if (iss_valid && iss_rd != '0) begin
            rd = int'(iss_rd);
            w  = (iss_wb_lat == '0) ? 1 : int'(iss_wb_lat);
            issC[rd] = cyc;
            retC[rd] = cyc + w;
            rdyC[rd] = cyc + ((int'(iss_rdy_lat) < w) ? int'(iss_rdy_lat) : w);
        end
        #1;
    endtask

    task automatic setIssue(bit v, int rd, int rl, int wl);
        iss_valid   = v;
        iss_rd      = ADDRW'(rd);
        iss_rdy_lat = LATW'(rl);
        iss_wb_lat  = LATW'(wl);
    endtask

    task automatic setDec(int r1, bit e1, int r2, bit e2, int rd, bit ed, int wl);
        dec_rs1 = ADDRW'(r1); dec_rs1_en = e1;
        dec_rs2 = ADDRW'(r2); dec_rs2_en = e2;
        dec_rd  = ADDRW'(rd); dec_rd_en  = ed;
        dec_wb_lat = LATW'(wl);
    endtask

    initial begin
        modelClear();
        $display("[TB] reset");
        #1;
        checkOutput("reset0");
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("reset1");
        checkVal("reset.mask", 32'(busy_mask), 32'h0);

        $display("[TB] ALU chain");
        setIssue(1, 5, 0, 3);
        setDec(5, 1, 0, 0, 0, 0, 0);
        applyStimulus();
        setIssue(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("alu");
            checkVal("alu.byp", 32'(rs1_byp), 32'd1);
            checkVal("alu.age", 32'(rs1_age), 32'(k));
            checkVal("alu.stall", 32'(stall), 32'd0);
            applyStimulus();
        end
        checkVal("alu.retired", 32'(busy_mask[5]), 32'd0);
        checkVal("alu.byp_off", 32'(rs1_byp), 32'd0);

        $display("[TB] load-use");
        setIssue(1, 7, 1, 3);
        setDec(0, 0, 7, 1, 0, 0, 0);
        applyStimulus();
        setIssue(0, 0, 0, 0);
        checkOutput("ld0");
        checkVal("ld.stall", 32'(stall), 32'd1);
        dec_rs2_en = 1'b0;
        #1;
        checkOutput("ld_dis");
        checkVal("ld.dis_stall", 32'(stall), 32'd0);
        dec_rs2_en = 1'b1;
        applyStimulus();
        checkOutput("ld1");
        checkVal("ld.stall_off", 32'(stall), 32'd0);
        checkVal("ld.byp", 32'(rs2_byp), 32'd1);
        checkVal("ld.age", 32'(rs2_age), 32'd1);
        applyStimulus();

        $display("[TB] x0 and disabled sources");
        setIssue(1, 0, 0, 5);
        setDec(0, 1, 0, 0, 0, 1, 0);
        applyStimulus();
        setIssue(0, 0, 0, 0);
        checkOutput("x0");
        checkVal("x0.mask", 32'(busy_mask), 32'h0);
        checkVal("x0.byp", 32'(rs1_byp), 32'd0);

        $display("[TB] WAW");
        setIssue(1, 9, 0, 3);
        setDec(0, 0, 0, 0, 9, 1, 1);
        applyStimulus();
        setIssue(0, 0, 0, 0);
        checkOutput("waw0");
        checkVal("waw.stall0", 32'(stall), 32'd1);
        applyStimulus();
        checkOutput("waw1");
        checkVal("waw.stall1", 32'(stall), 32'd1);
        applyStimulus();
        checkOutput("waw2");
        checkVal("waw.stall2", 32'(stall), 32'd0);
        setIssue(1, 9, 0, 5);
        setDec(9, 1, 0, 0, 0, 0, 0);
        applyStimulus();
        setIssue(0, 0, 0, 0);
        checkOutput("reissue");
        checkVal("reissue.busy", 32'(busy_mask[9]), 32'd1);
        checkVal("reissue.age", 32'(rs1_age), 32'd0);

        $display("[TB] flush");
        setDec(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            setIssue(1, 10 + k, 1, 7);
            applyStimulus();
        end
        setIssue(1, 3, 0, 4);
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        setIssue(0, 0, 0, 0);
        checkOutput("flush");
        checkVal("flush.mask", 32'(busy_mask), 32'h0);
        checkVal("flush.count", 32'(pending_count), 32'd0);

        $display("[TB] async reset");
        for (int k = 0; k < 3; k++) begin
            setIssue(1, 20 + k, 2, 7);
            applyStimulus();
        end
        setIssue(0, 0, 0, 0);
        setDec(20, 1, 21, 1, 22, 1, 1);
        #3;
        reset = 1'b1;
        modelClear();
        #1;
        checkOutput("areset");
        checkVal("areset.mask", 32'(busy_mask), 32'h0);
        checkVal("areset.count", 32'(pending_count), 32'd0);
        checkVal("areset.stall", 32'(stall), 32'd0);
        #1;
        reset = 1'b0;
        applyStimulus();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            setIssue($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            clear = ($urandom_range(0, 39) == 0);
            setDec(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)));
            #1;
            checkOutput("rand");
            applyStimulus();
        end
        clear = 1'b0;
        setIssue(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard that generalises the RV32I pipeline's fixed load-use, write-back and store stall rules to producers of arbitrary, per-instruction latency. It sits beside the decode stage. It records every register-writing instruction as it issues from decode into execute. Each cycle it tells decode whether the instruction currently being decoded must stall. For every source operand that can be bypassed, it also reports how many cycles ago its producer issued, so the bypass muxes can pick the pipeline stage that holds the value.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- ADDRW, $clog2(NREGS), register-address width.
- LATW, 3, width of the latency and age counters; maximum latency is 2^LATW-1.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dec_rs1, dec_rs2  in  ADDRW each  source addresses of the instruction in decode.
- dec_rs1_en, dec_rs2_en  in  1 each  source actually read by the decode instruction; low for U/J types, and rs2 is low for I types.
- dec_rd  in  ADDRW  destination of the decode instruction.
- dec_rd_en  in  1  decode instruction writes a register.
- dec_wb_lat  in  LATW  write-back latency the decode instruction will have.
- stall  out  1  combinational; decode must hold and insert a bubble.
- rs1_byp, rs2_byp  out  1 each  combinational; the operand must come from the bypass network, not the register file.
- rs1_age, rs2_age  out  LATW each  combinational; cycles since the operand's producer issued.
- iss_valid  in  1  an instruction moves decode to execute on this edge.
- iss_rd  in  ADDRW  destination of the issuing instruction.
- iss_rdy_lat  in  LATW  bubbles a directly following consumer needs: ALU 0, load 1.
- iss_wb_lat  in  LATW  edges from issue until the register file holds the result; must be at least 1.
- clear  in  1  synchronous flush of all entries (exception/redirect).
- busy_mask  out  NREGS  bit r is 1 while register r has a pending write; bit 0 is always 0.
- pending_count  out  ADDRW+1  popcount of busy_mask.

## Operation
- Each register r in 1..NREGS-1 has one entry: busy, rdy[LATW], wb[LATW], age[LATW].
- **Issue.** On an edge where iss_valid=1 and iss_rd!=0, entry iss_rd is loaded:
  - busy=1, rdy=min(iss_rdy_lat, iss_wb_lat), wb=iss_wb_lat, age=0.
  - If iss_wb_lat=0, it is treated as 1.
  - Issue overrides any older entry for the same register, including one retiring on the same edge.
  - iss_rd=0 is ignored.
- **Ageing.** On each edge, every other busy entry updates:
  - rdy decrements and saturates at 0.
  - wb decrements.
  - age increments and saturates at 2^LATW-1.
  - When wb reaches 0 the entry clears (busy=0, all fields 0).
- **RAW check**, per source X:
  - hazX = dec_rsX_en, dec_rsX!=0, busy[rsX] and rdy[rsX]!=0.
  - rsX_byp = dec_rsX_en, dec_rsX!=0, busy and rdy=0.
  - rsX_age = age[rsX] when byp=1, else 0.
- **WAW check.** waw = dec_rd_en, dec_rd!=0, busy[rd] and wb[rd] > dec_wb_lat, so that a younger, faster result is never overwritten by an older one.
- stall = haz1 OR haz2 OR waw.
- The scoreboard does not gate issue itself. The pipeline drives iss_valid=0 whenever it stalls or squashes.
- **clear** sets all entries idle on the edge. clear wins over a simultaneous iss_valid.
- **reset** asynchronously sets all entries idle, whatever operation is in progress.

## Timing
- Check outputs are combinational from entry state and dec_* only, with no dependence on iss_*. An instruction issuing on edge e is visible to decode from cycle e onward.
- Bypass age meaning for the consumer's next X cycle: age 0 means the producer is in M (MX path); age 1 means it is in W (WX path).
- Reset values: busy_mask=0, pending_count=0, stall=0, rsX_byp=0, rsX_age=0.
- Entry lifetime is exactly iss_wb_lat edges. The load-use stall lasts exactly iss_rdy_lat cycles.

## Test plan
- **Reset.** Issue three registers, then assert reset asynchronously mid-cycle -> busy_mask=0 and pending_count=0 immediately, before the next edge; stall=0.
- **ALU chain.** Issue x5 (rdy 0, wb 3), then decode rs1=x5 over the following cycles -> stall=0 and rs1_byp=1 with rs1_age=0, then 1, then 2; after the 3rd edge, busy_mask[5]=0 and rs1_byp=0.
- **Load-use.** Issue x7 (rdy 1, wb 3), then decode rs2=x7 with rs2_en=1 -> stall=1 for exactly one cycle, then stall=0, rs2_byp=1, rs2_age=1. The same case with rs2_en=0 -> stall=0.
- **x0 and disabled sources.** Issue rd=0 -> busy_mask unchanged. Decode rs1=0 -> stall=0 and byp=0.
- **WAW.** Issue x9 (wb 3), then decode rd=x9 with dec_wb_lat=1 -> stall=1 for 2 cycles, then 0. Re-issuing x9 on the edge where the old entry retires -> the entry shows the new fields (age 0).
- **Flush.** With 4 entries busy, assert clear together with iss_valid (rd=x3) -> busy_mask=0 and pending_count=0 after the edge.
